ddr_queue_manager: RTL and testbench

DDR_QUEUE_MANAGER -- requirements
Module: ddr_queue_manager

---
 rtl/ddr_queue_pkg.sv | 30 +++
 rtl/ddr_desc_fifo.sv | 49 ++++
 rtl/ddr_queue_manager.sv | 178 +++++++++++++++++
 tb/tb_ddr_queue_manager.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_queue_pkg.sv
// Shared types and sizing helpers for the DDR slot queue manager.
package ddr_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT_CPL
  } rd_state_t;

  localparam int unsigned DEF_SLOT_BYTES  = 2048;
  localparam int unsigned DEF_QUEUE_SLOTS = 16;
  localparam int unsigned DESC_LEN_W      = 16;
  localparam int unsigned DESC_STRB_W     = 8;

  // Width needed to hold an occupancy of 0..slots inclusive.
  function automatic int unsigned level_width(input int unsigned slots);
    return $clog2(slots + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  function automatic longint unsigned region_bytes(input int unsigned slot_bytes,
                                                   input int unsigned slots);
    return longint'(slot_bytes) * longint'(slots);
  endfunction

endpackage

// File: rtl/ddr_desc_fifo.sv
// Per-queue FIFO of completed-write descriptors awaiting read-back.
module ddr_desc_fifo
  import ddr_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_QUEUE_SLOTS,
  parameter int unsigned WIDTH = 56
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign push_ok = push && (count != CW'(DEPTH));
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ddr_queue_manager.sv
// DDR slot allocator and round-robin read-back scheduler for one-hot queues.
// Define DDR_QUEUE_STATS_EN to build the saturating allocation-stall counter.
module ddr_queue_manager
  import ddr_queue_pkg::*;
#(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h00000000,
  parameter int unsigned C_M_AXI_ADDR_WIDTH         = 32,
  parameter int unsigned P_DDR_LOCAL_QUEUE          = 4,
  parameter int unsigned P_SLOT_BYTES               = DEF_SLOT_BYTES,
  parameter int unsigned P_QUEUE_SLOTS              = DEF_QUEUE_SLOTS
) (
  input  logic                                                   M_AXI_ACLK,
  input  logic                                                   M_AXI_ARESETN,
  input  logic                                                   i_wr_ddr_valid,
  input  logic [15:0]                                            i_wr_ddr_len,
  input  logic [P_DDR_LOCAL_QUEUE-1:0]                           i_wr_ddr_queue,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]                          o_wr_ddr_addr,
  output logic                                                   o_wr_ddr_ready,
  input  logic                                                   i_wr_ddr_cpl_valid,
  output logic                                                   o_wr_ddr_cpl_ready,
  input  logic [P_DDR_LOCAL_QUEUE-1:0]                           i_wr_ddr_cpl_queue,
  input  logic [15:0]                                            i_wr_ddr_cpl_len,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]                          i_wr_ddr_cpl_addr,
  input  logic [7:0]                                             i_wr_ddr_cpl_strb,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]                          o_rd_ddr_addr,
  output logic [15:0]                                            o_rd_ddr_len,
  output logic [7:0]                                             o_rd_ddr_strb,
  output logic                                                   o_rd_ddr_valid,
  input  logic                                                   i_rd_ddr_ready,
  input  logic                                                   i_rd_ddr_cpl,
  output logic [P_DDR_LOCAL_QUEUE*level_width(P_QUEUE_SLOTS)-1:0] o_queue_level,
  output logic                                                   o_len_err,
  output logic [31:0]                                            o_stall_cnt
);

  localparam int unsigned NQ = P_DDR_LOCAL_QUEUE;
  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned LW = level_width(P_QUEUE_SLOTS);
  localparam int unsigned PW = ptr_width(P_QUEUE_SLOTS);
  localparam int unsigned QW = ptr_width(NQ);
  localparam int unsigned DW = AW + DESC_LEN_W + DESC_STRB_W;
  localparam logic [AW-1:0] SLOT_SZ   = AW'(P_SLOT_BYTES);
  localparam logic [AW-1:0] REGION_SZ = AW'(region_bytes(P_SLOT_BYTES, P_QUEUE_SLOTS));

  rd_state_t        state;
  logic [LW-1:0]    occ       [NQ];
  logic [PW-1:0]    alloc_ptr [NQ];
  logic [PW-1:0]    rd_ptr    [NQ];
  logic [QW-1:0]    wr_idx;
  logic [QW-1:0]    rd_sel;
  logic [QW-1:0]    rr_next;
  logic [QW-1:0]    rr_pick;
  logic [QW-1:0]    cand;
  logic [NQ-1:0]    alloc_hit;
  logic [NQ-1:0]    rel_hit;
  logic [NQ-1:0]    fifo_push;
  logic [NQ-1:0]    fifo_pop;
  logic [NQ-1:0]    fifo_empty;
  logic [DW-1:0]    fifo_dout [NQ];
  logic [DW-1:0]    cpl_desc;

  always_comb begin
    wr_idx = '0;
    for (int unsigned i = 0; i < NQ; i++) begin
      if (i_wr_ddr_queue[i]) wr_idx = QW'(i);
    end
  end

  assign o_wr_ddr_ready = i_wr_ddr_valid && $onehot(i_wr_ddr_queue) &&
                          (occ[wr_idx] < LW'(P_QUEUE_SLOTS));
  assign o_wr_ddr_addr  = AW'(C_M_TARGET_SLAVE_BASE_ADDR) + AW'(wr_idx) * REGION_SZ +
                          AW'(alloc_ptr[wr_idx]) * SLOT_SZ;

  assign cpl_desc  = {i_wr_ddr_cpl_addr, i_wr_ddr_cpl_len, i_wr_ddr_cpl_strb};
  assign fifo_push = (i_wr_ddr_cpl_valid && o_wr_ddr_cpl_ready && $onehot(i_wr_ddr_cpl_queue))
                     ? i_wr_ddr_cpl_queue : '0;
  assign fifo_pop  = (state == ST_ISSUE && o_rd_ddr_valid && i_rd_ddr_ready)
                     ? (NQ'(1) << rd_sel) : '0;

  for (genvar g = 0; g < NQ; g++) begin : g_queue
    ddr_desc_fifo #(
      .DEPTH (P_QUEUE_SLOTS),
      .WIDTH (DW)
    ) u_fifo (
      .clk   (M_AXI_ACLK),
      .rst_n (M_AXI_ARESETN),
      .push  (fifo_push[g]),
      .din   (cpl_desc),
      .pop   (fifo_pop[g]),
      .dout  (fifo_dout[g]),
      .empty (fifo_empty[g])
    );
    assign o_queue_level[g*LW +: LW] = occ[g];
  end

  // Scan from the farthest offset down so the nearest non-empty queue after rr_next wins.
  always_comb begin
    rr_pick = rr_next;
    cand    = '0;
    for (int unsigned k = NQ; k > 0; k--) begin
      cand = QW'((32'(rr_next) + k - 1) % NQ);
      if (!fifo_empty[cand]) rr_pick = cand;
    end
  end

  always_comb begin
    alloc_hit = '0;
    rel_hit   = '0;
    if (o_wr_ddr_ready) alloc_hit[wr_idx] = 1'b1;
    if (state == ST_WAIT_CPL && i_rd_ddr_cpl) rel_hit[rd_sel] = 1'b1;
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state              <= ST_IDLE;
      rd_sel             <= '0;
      rr_next            <= '0;
      o_rd_ddr_valid     <= 1'b0;
      o_rd_ddr_addr      <= '0;
      o_rd_ddr_len       <= '0;
      o_rd_ddr_strb      <= '0;
      o_wr_ddr_cpl_ready <= 1'b0;
    end else begin
      o_wr_ddr_cpl_ready <= 1'b1;
      case (state)
        ST_IDLE: if (!(&fifo_empty)) state <= ST_ARB;
        ST_ARB: begin
          rd_sel  <= rr_pick;
          rr_next <= (32'(rr_pick) == NQ - 1) ? '0 : rr_pick + 1'b1;
          state   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!o_rd_ddr_valid) begin
            {o_rd_ddr_addr, o_rd_ddr_len, o_rd_ddr_strb} <= fifo_dout[rd_sel];
            o_rd_ddr_valid <= 1'b1;
          end else if (i_rd_ddr_ready) begin
            o_rd_ddr_valid <= 1'b0;
            state          <= ST_WAIT_CPL;
          end
        end
        ST_WAIT_CPL: if (i_rd_ddr_cpl) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      o_len_err <= 1'b0;
      for (int unsigned i = 0; i < NQ; i++) begin
        occ[i]       <= '0;
        alloc_ptr[i] <= '0;
        rd_ptr[i]    <= '0;
      end
    end else begin
      if (o_wr_ddr_ready && (32'(i_wr_ddr_len) > P_SLOT_BYTES)) o_len_err <= 1'b1;
      for (int unsigned i = 0; i < NQ; i++) begin
        if (alloc_hit[i] && !rel_hit[i])                     occ[i] <= occ[i] + 1'b1;
        else if (rel_hit[i] && !alloc_hit[i] && occ[i] != '0) occ[i] <= occ[i] - 1'b1;
        if (alloc_hit[i]) alloc_ptr[i] <= alloc_ptr[i] + 1'b1;
        if (rel_hit[i])   rd_ptr[i]    <= rd_ptr[i] + 1'b1;
      end
    end
  end

`ifdef DDR_QUEUE_STATS_EN
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      o_stall_cnt <= '0;
    end else if (i_wr_ddr_valid && !o_wr_ddr_ready && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr_queue_manager.sv
// Scoreboard bench for ddr_queue_manager: directed allocation, read-back and reset vectors.
module tb_ddr_queue_manager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_wr_ddr_valid = 1'b0;
  logic [15:0] i_wr_ddr_len = '0;
  logic [3:0]  i_wr_ddr_queue = '0;
  logic [31:0] o_wr_ddr_addr;
  logic        o_wr_ddr_ready;
  logic        i_wr_ddr_cpl_valid = 1'b0;
  logic        o_wr_ddr_cpl_ready;
  logic [3:0]  i_wr_ddr_cpl_queue = '0;
  logic [15:0] i_wr_ddr_cpl_len = '0;
  logic [31:0] i_wr_ddr_cpl_addr = '0;
  logic [7:0]  i_wr_ddr_cpl_strb = '0;
  logic [31:0] o_rd_ddr_addr;
  logic [15:0] o_rd_ddr_len;
  logic [7:0]  o_rd_ddr_strb;
  logic        o_rd_ddr_valid;
  logic        i_rd_ddr_ready = 1'b0;
  logic        i_rd_ddr_cpl = 1'b0;
  logic [19:0] o_queue_level;
  logic        o_len_err;
  logic [31:0] o_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] alloc_sb [$];
  logic [55:0] rd_sb    [$];

  always #5 clk = ~clk;

  ddr_queue_manager #(
    .C_M_TARGET_SLAVE_BASE_ADDR (32'h00000000),
    .C_M_AXI_ADDR_WIDTH         (32),
    .P_DDR_LOCAL_QUEUE          (4),
    .P_SLOT_BYTES               (2048),
    .P_QUEUE_SLOTS              (16)
  ) dut (
    .M_AXI_ACLK         (clk),
    .M_AXI_ARESETN      (rst_n),
    .i_wr_ddr_valid     (i_wr_ddr_valid),
    .i_wr_ddr_len       (i_wr_ddr_len),
    .i_wr_ddr_queue     (i_wr_ddr_queue),
    .o_wr_ddr_addr      (o_wr_ddr_addr),
    .o_wr_ddr_ready     (o_wr_ddr_ready),
    .i_wr_ddr_cpl_valid (i_wr_ddr_cpl_valid),
    .o_wr_ddr_cpl_ready (o_wr_ddr_cpl_ready),
    .i_wr_ddr_cpl_queue (i_wr_ddr_cpl_queue),
    .i_wr_ddr_cpl_len   (i_wr_ddr_cpl_len),
    .i_wr_ddr_cpl_addr  (i_wr_ddr_cpl_addr),
    .i_wr_ddr_cpl_strb  (i_wr_ddr_cpl_strb),
    .o_rd_ddr_addr      (o_rd_ddr_addr),
    .o_rd_ddr_len       (o_rd_ddr_len),
    .o_rd_ddr_strb      (o_rd_ddr_strb),
    .o_rd_ddr_valid     (o_rd_ddr_valid),
    .i_rd_ddr_ready     (i_rd_ddr_ready),
    .i_rd_ddr_cpl       (i_rd_ddr_cpl),
    .o_queue_level      (o_queue_level),
    .o_len_err          (o_len_err),
    .o_stall_cnt        (o_stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted allocation and read handshake is matched against the scoreboards.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_wr_ddr_ready) begin
        n_tests++;
        if (alloc_sb.size() == 0) begin
          n_fail++;
          $display("FAIL alloc_unexpected: got addr 0x%0h, expected no allocation", o_wr_ddr_addr);
        end else begin
          logic [31:0] ea;
          ea = alloc_sb.pop_front();
          if (o_wr_ddr_addr !== ea) begin
            n_fail++;
            $display("FAIL alloc_addr: got 0x%0h, expected 0x%0h", o_wr_ddr_addr, ea);
          end
        end
      end
      if (o_rd_ddr_valid && i_rd_ddr_ready) begin
        n_tests++;
        if (rd_sb.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: got addr 0x%0h, expected no read", o_rd_ddr_addr);
        end else begin
          logic [55:0] ed;
          ed = rd_sb.pop_front();
          if ({o_rd_ddr_addr, o_rd_ddr_len, o_rd_ddr_strb} !== ed) begin
            n_fail++;
            $display("FAIL rd_desc: got 0x%0h, expected 0x%0h",
                     {o_rd_ddr_addr, o_rd_ddr_len, o_rd_ddr_strb}, ed);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Entered and left just after a rising edge.
  task automatic alloc(input logic [3:0] q, input logic [15:0] len,
                       input logic exp_ready, input logic [31:0] exp_addr);
    i_wr_ddr_valid = 1'b1;
    i_wr_ddr_queue = q;
    i_wr_ddr_len   = len;
    if (exp_ready) alloc_sb.push_back(exp_addr);
    @(negedge clk);
    check("wr_ready", 64'(o_wr_ddr_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
    i_wr_ddr_valid = 1'b0;
    i_wr_ddr_queue = '0;
  endtask

  task automatic cpl(input logic [3:0] q, input logic [31:0] a,
                     input logic [15:0] l, input logic [7:0] s);
    check("cpl_ready", 64'(o_wr_ddr_cpl_ready), 64'(1));
    i_wr_ddr_cpl_valid = 1'b1;
    i_wr_ddr_cpl_queue = q;
    i_wr_ddr_cpl_addr  = a;
    i_wr_ddr_cpl_len   = l;
    i_wr_ddr_cpl_strb  = s;
    @(posedge clk);
    #1;
    i_wr_ddr_cpl_valid = 1'b0;
  endtask

  task automatic serve_read(input int hold, input logic [31:0] ea, input logic [15:0] el,
                            input logic [7:0] es, input bit do_cpl);
    bit seen;
    seen = 1'b0;
    rd_sb.push_back({ea, el, es});
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = o_rd_ddr_valid;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL rd_valid_timeout: got no o_rd_ddr_valid in 20 cycles, expected addr 0x%0h", ea);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 64'(o_rd_ddr_valid), 64'(1));
      check("hold_addr",  64'(o_rd_ddr_addr),  64'(ea));
      check("hold_len",   64'(o_rd_ddr_len),   64'(el));
      check("hold_strb",  64'(o_rd_ddr_strb),  64'(es));
      @(negedge clk);
    end
    @(posedge clk);
    #1 i_rd_ddr_ready = 1'b1;
    @(posedge clk);
    #1 i_rd_ddr_ready = 1'b0;
    check("rd_valid_drop", 64'(o_rd_ddr_valid), 64'(0));
    if (do_cpl) begin
      i_rd_ddr_cpl = 1'b1;
      @(posedge clk);
      #1 i_rd_ddr_cpl = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_rd_valid",  64'(o_rd_ddr_valid),     64'(0));
    check("rst_cpl_ready", 64'(o_wr_ddr_cpl_ready), 64'(0));
    check("rst_level",     64'(o_queue_level),      64'(0));
    check("rst_len_err",   64'(o_len_err),          64'(0));
    check("rst_stall",     64'(o_stall_cnt),        64'(0));

    // Queue 2 slot addressing and illegal queue selects.
    do_reset();
    alloc(4'b0100, 16'd64, 1'b1, 32'h0001_0000);
    alloc(4'b0100, 16'd64, 1'b1, 32'h0001_0800);
    check("level_q2", 64'(o_queue_level[14:10]), 64'(2));
    alloc(4'b0000, 16'd64, 1'b0, 32'h0);
    alloc(4'b0011, 16'd64, 1'b0, 32'h0);
    check("level_after_bad_q", 64'(o_queue_level), 64'(20'h00800));
    check("len_err_clear", 64'(o_len_err), 64'(0));

    // Fill queue 0, stall, free one slot, allocation wraps to slot 0.
    do_reset();
    for (int i = 0; i < 16; i++) alloc(4'b0001, 16'd128, 1'b1, 32'(i) * 32'h800);
    check("level_q0_full", 64'(o_queue_level), 64'(16));
    i_wr_ddr_valid = 1'b1;
    i_wr_ddr_queue = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("full_ready", 64'(o_wr_ddr_ready), 64'(0));
`ifdef DDR_QUEUE_STATS_EN
      check("stall_cnt", 64'(o_stall_cnt), 64'(k));
`else
      check("stall_cnt_off", 64'(o_stall_cnt), 64'(0));
`endif
    end
    @(posedge clk);
    #1;
    i_wr_ddr_valid = 1'b0;
    i_wr_ddr_queue = '0;
    cpl(4'b0001, 32'h0, 16'd128, 8'hFF);
    serve_read(0, 32'h0, 16'd128, 8'hFF, 1'b1);
    check("level_q0_freed", 64'(o_queue_level), 64'(15));
    alloc(4'b0001, 16'd128, 1'b1, 32'h0);
    check("level_q0_refill", 64'(o_queue_level), 64'(16));

    // Round robin: q1, q3, then the second q1 descriptor; first read held off 5 cycles.
    do_reset();
    alloc(4'b0010, 16'd100, 1'b1, 32'h0000_8000);
    alloc(4'b0010, 16'd300, 1'b1, 32'h0000_8800);
    alloc(4'b1000, 16'd200, 1'b1, 32'h0001_8000);
    cpl(4'b0010, 32'h0000_8000, 16'd100, 8'h0F);
    cpl(4'b1000, 32'h0001_8000, 16'd200, 8'hF0);
    cpl(4'b0010, 32'h0000_8800, 16'd300, 8'h3C);
    serve_read(5, 32'h0000_8000, 16'd100, 8'h0F, 1'b1);
    serve_read(0, 32'h0001_8000, 16'd200, 8'hF0, 1'b1);
    serve_read(0, 32'h0000_8800, 16'd300, 8'h3C, 1'b1);
    check("level_rr_drained", 64'(o_queue_level), 64'(0));

    // Oversize length, then reset while waiting for read completion.
    do_reset();
    alloc(4'b0010, 16'd3000, 1'b1, 32'h0000_8000);
    check("len_err_set", 64'(o_len_err), 64'(1));
    cpl(4'b0010, 32'h0000_8000, 16'd3000, 8'hFF);
    serve_read(0, 32'h0000_8000, 16'd3000, 8'hFF, 1'b0);
    check("level_q1_wait", 64'(o_queue_level), 64'(20'h00020));
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd_valid",  64'(o_rd_ddr_valid),     64'(0));
    check("arst_rd_addr",   64'(o_rd_ddr_addr),      64'(0));
    check("arst_rd_len",    64'(o_rd_ddr_len),       64'(0));
    check("arst_rd_strb",   64'(o_rd_ddr_strb),      64'(0));
    check("arst_len_err",   64'(o_len_err),          64'(0));
    check("arst_level",     64'(o_queue_level),      64'(0));
    check("arst_stall",     64'(o_stall_cnt),        64'(0));
    check("arst_cpl_ready", 64'(o_wr_ddr_cpl_ready), 64'(0));
    check("arst_wr_ready",  64'(o_wr_ddr_ready),     64'(0));
    check("arst_wr_addr",   64'(o_wr_ddr_addr),      64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    alloc(4'b0001, 16'd64, 1'b1, 32'h0);
    i_rd_ddr_cpl = 1'b1;
    @(posedge clk);
    #1 i_rd_ddr_cpl = 1'b0;
    check("stray_cpl_ignored", 64'(o_queue_level), 64'(1));
    repeat (3) @(negedge clk);
    check("no_stray_read", 64'(o_rd_ddr_valid), 64'(0));

    check("alloc_sb_drained", 64'(alloc_sb.size()), 64'(0));
    check("rd_sb_drained",    64'(rd_sb.size()),    64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
